scancode_decoder: RTL and testbench

SCANCODE_DECODER -- requirements
Module: scancode_decoder

---
 rtl/scancode_decoder.sv | 163 ++++++++++++++++
 tb/tb_scancode_decoder.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scancode_decoder.sv
// PS/2 Set 2 scancode decoder: tracks make/break/extended prefixes and modifiers,
// translates key presses to ASCII and buffers them in a small FIFO for the CPU.
module scancode_decoder #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] scan_code,
    input  logic       scan_valid,
    input  logic       cpu_ack,
    output logic [7:0] ascii_out,
    output logic       cpu_intr,
    output logic       overrun
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_BRK, S_EXT, S_EXT_BRK} state_t;

    state_t        state_q, state_d;
    logic          shift_l_q, shift_l_d;
    logic          shift_r_q, shift_r_d;
    logic          caps_q, caps_d;
    logic          ack_prev_q;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CW-1:0] count_q;
    logic          overrun_q;

    logic          char_valid;
    logic [7:0]    char_data;
    logic          ack_rise, full, push, pop, drop;

    // Returns {valid, ascii} for a non-extended make code.
    function automatic logic [8:0] map_make(input logic [7:0] code,
                                            input logic shift,
                                            input logic caps);
        logic [7:0] lc, dg, sy;
        logic [8:0] res;
        lc  = 8'h00;
        dg  = 8'h00;
        sy  = 8'h00;
        res = 9'h000;
        case (code)
            8'h1C: lc = "a";  8'h32: lc = "b";  8'h21: lc = "c";  8'h23: lc = "d";
            8'h24: lc = "e";  8'h2B: lc = "f";  8'h34: lc = "g";  8'h33: lc = "h";
            8'h43: lc = "i";  8'h3B: lc = "j";  8'h42: lc = "k";  8'h4B: lc = "l";
            8'h3A: lc = "m";  8'h31: lc = "n";  8'h44: lc = "o";  8'h4D: lc = "p";
            8'h15: lc = "q";  8'h2D: lc = "r";  8'h1B: lc = "s";  8'h2C: lc = "t";
            8'h3C: lc = "u";  8'h2A: lc = "v";  8'h1D: lc = "w";  8'h22: lc = "x";
            8'h35: lc = "y";  8'h1A: lc = "z";
            8'h45: begin dg = "0"; sy = ")"; end
            8'h16: begin dg = "1"; sy = "!"; end
            8'h1E: begin dg = "2"; sy = "@"; end
            8'h26: begin dg = "3"; sy = "#"; end
            8'h25: begin dg = "4"; sy = "$"; end
            8'h2E: begin dg = "5"; sy = "%"; end
            8'h36: begin dg = "6"; sy = "^"; end
            8'h3D: begin dg = "7"; sy = "&"; end
            8'h3E: begin dg = "8"; sy = "*"; end
            8'h46: begin dg = "9"; sy = "("; end
            8'h29: res = {1'b1, 8'h20};
            8'h5A: res = {1'b1, 8'h0D};
            8'h66: res = {1'b1, 8'h08};
            8'h0D: res = {1'b1, 8'h09};
            8'h76: res = {1'b1, 8'h1B};
            default: res = 9'h000;
        endcase
        if (lc != 8'h00) begin
            res = {1'b1, (shift ^ caps) ? (lc - 8'h20) : lc};
        end else if (dg != 8'h00) begin
            res = {1'b1, shift ? sy : dg};
        end
        return res;
    endfunction

    always_comb begin
        state_d    = state_q;
        shift_l_d  = shift_l_q;
        shift_r_d  = shift_r_q;
        caps_d     = caps_q;
        char_valid = 1'b0;
        char_data  = 8'h00;
        if (scan_valid) begin
            state_d = S_IDLE;
            case (state_q)
                S_IDLE: begin
                    if (scan_code == 8'hE0) begin
                        state_d = S_EXT;
                    end else if (scan_code == 8'hF0) begin
                        state_d = S_BRK;
                    end else if (scan_code == 8'h12) begin
                        shift_l_d = 1'b1;
                    end else if (scan_code == 8'h59) begin
                        shift_r_d = 1'b1;
                    end else if (scan_code == 8'h58) begin
                        caps_d = ~caps_q;
                    end else begin
                        {char_valid, char_data} = map_make(scan_code, shift_l_q | shift_r_q, caps_q);
                    end
                end
                S_BRK: begin
                    if (scan_code == 8'h12) shift_l_d = 1'b0;
                    if (scan_code == 8'h59) shift_r_d = 1'b0;
                end
                S_EXT: begin
                    if (scan_code == 8'hF0) begin
                        state_d = S_EXT_BRK;
                    end else if (scan_code == 8'h5A) begin
                        char_valid = 1'b1;
                        char_data  = 8'h0D;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push then.
    assign ack_rise = cpu_ack & ~ack_prev_q;
    assign pop      = ack_rise && (count_q != '0);
    assign full     = (count_q == CW'(FIFO_DEPTH));
    assign push     = char_valid && (!full || pop);
    assign drop     = char_valid && full && !pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            shift_l_q  <= 1'b0;
            shift_r_q  <= 1'b0;
            caps_q     <= 1'b0;
            ack_prev_q <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_l_q  <= shift_l_d;
            shift_r_q  <= shift_r_d;
            caps_q     <= caps_d;
            ack_prev_q <= cpu_ack;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            if (drop) overrun_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= char_data;
    end

    assign cpu_intr  = (count_q != '0);
    assign ascii_out = cpu_intr ? mem_q[rd_ptr_q] : 8'h00;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_scancode_decoder.sv
// Directed bench for scancode_decoder: each task drives a scenario and checks
// outputs against hand-computed ASCII values.
module tb_scancode_decoder;

    logic       clk;
    logic       rst;
    logic [7:0] scan_code;
    logic       scan_valid;
    logic       cpu_ack;
    logic [7:0] ascii_out;
    logic       cpu_intr;
    logic       overrun;

    int total = 0;
    int bad   = 0;

    localparam logic [7:0] MAP_CODE [10] = '{8'h45, 8'h3D, 8'h15, 8'h32, 8'h1A,
                                             8'h66, 8'h0D, 8'h76, 8'h5A, 8'h29};
    localparam logic [7:0] MAP_EXP  [10] = '{8'h30, 8'h37, 8'h71, 8'h62, 8'h7A,
                                             8'h08, 8'h09, 8'h1B, 8'h0D, 8'h20};
    localparam logic [7:0] SH_CODE  [4]  = '{8'h1E, 8'h46, 8'h45, 8'h2E};
    localparam logic [7:0] SH_EXP   [4]  = '{8'h40, 8'h28, 8'h29, 8'h25};

    scancode_decoder #(.FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .scan_code  (scan_code),
        .scan_valid (scan_valid),
        .cpu_ack    (cpu_ack),
        .ascii_out  (ascii_out),
        .cpu_intr   (cpu_intr),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        scan_code  = b;
        scan_valid = 1'b1;
        @(negedge clk);
        scan_valid = 1'b0;
        $display("tx scan 0x%02h -> ascii=0x%02h intr=%0b ovr=%0b", b, ascii_out, cpu_intr, overrun);
    endtask

    task automatic ack();
        @(negedge clk);
        cpu_ack = 1'b1;
        @(negedge clk);
        cpu_ack = 1'b0;
        $display("tx ack -> ascii=0x%02h intr=%0b", ascii_out, cpu_intr);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        scan_code = 8'h00; scan_valid = 1'b0; cpu_ack = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (ascii_out !== 8'h00 || cpu_intr !== 1'b0 || overrun !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: got ascii=%h intr=%b ovr=%b, want 00 0 0", ascii_out, cpu_intr, overrun);
        end
        rst = 1'b0;
        send(8'h1C);
        #2 rst = 1'b1;
        #1;
        total++;
        if (cpu_intr !== 1'b0 || ascii_out !== 8'h00) begin
            bad++;
            $display("FAIL async_reset: got intr=%b ascii=%h, want 0 00", cpu_intr, ascii_out);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        do_reset();
        send(8'h1C);
        total++;
        if (cpu_intr !== 1'b1 || ascii_out !== 8'h61) begin
            bad++;
            $display("FAIL basic_first: got intr=%b ascii=%h, want 1 61", cpu_intr, ascii_out);
        end
        send(8'hF0);
        send(8'h1C);
        ack();
        total++;
        if (cpu_intr !== 1'b0 || ascii_out !== 8'h00) begin
            bad++;
            $display("FAIL basic_pop: got intr=%b ascii=%h, want 0 00", cpu_intr, ascii_out);
        end
    endtask

    task automatic test_shift();
        logic [7:0] exp [3];
        exp = '{8'h41, 8'h21, 8'h61};
        do_reset();
        send(8'h12); send(8'h1C); send(8'h16);
        send(8'hF0); send(8'h12); send(8'h1C);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (ascii_out !== exp[i] || cpu_intr !== 1'b1) begin
                bad++;
                $display("FAIL shift_entry%0d: got ascii=%h intr=%b, want %h 1", i, ascii_out, cpu_intr, exp[i]);
            end
            ack();
        end
        total++;
        if (cpu_intr !== 1'b0) begin
            bad++;
            $display("FAIL shift_empty: got intr=%b, want 0", cpu_intr);
        end
    endtask

    task automatic test_caps();
        logic [7:0] exp [3];
        exp = '{8'h41, 8'h61, 8'h21};
        do_reset();
        send(8'h58); send(8'hF0); send(8'h58); send(8'h1C);
        send(8'h12); send(8'h1C); send(8'h16);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (ascii_out !== exp[i]) begin
                bad++;
                $display("FAIL caps_entry%0d: got ascii=%h, want %h", i, ascii_out, exp[i]);
            end
            ack();
        end
        send(8'hF0); send(8'h12); send(8'h16);
        total++;
        if (ascii_out !== 8'h31) begin
            bad++;
            $display("FAIL caps_digit: got ascii=%h, want 31", ascii_out);
        end
        ack();
    endtask

    task automatic test_map();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            send(MAP_CODE[i]);
            total++;
            if (ascii_out !== MAP_EXP[i] || cpu_intr !== 1'b1) begin
                bad++;
                $display("FAIL map_%02h: got ascii=%h intr=%b, want %h 1", MAP_CODE[i], ascii_out, cpu_intr, MAP_EXP[i]);
            end
            ack();
        end
        send(8'h59);
        for (int i = 0; i < 4; i++) begin
            send(SH_CODE[i]);
            total++;
            if (ascii_out !== SH_EXP[i]) begin
                bad++;
                $display("FAIL shmap_%02h: got ascii=%h, want %h", SH_CODE[i], ascii_out, SH_EXP[i]);
            end
            ack();
        end
        send(8'h05);
        total++;
        if (cpu_intr !== 1'b0) begin
            bad++;
            $display("FAIL unmapped: got intr=%b, want 0", cpu_intr);
        end
    endtask

    task automatic test_overrun();
        do_reset();
        for (int i = 0; i < 4; i++) send(8'h29);
        total++;
        if (overrun !== 1'b0) begin
            bad++;
            $display("FAIL ovr_not_yet: got ovr=%b, want 0", overrun);
        end
        send(8'h29);
        total++;
        if (overrun !== 1'b1) begin
            bad++;
            $display("FAIL ovr_set: got ovr=%b, want 1", overrun);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (ascii_out !== 8'h20 || cpu_intr !== 1'b1) begin
                bad++;
                $display("FAIL ovr_read%0d: got ascii=%h intr=%b, want 20 1", i, ascii_out, cpu_intr);
            end
            ack();
        end
        total++;
        if (cpu_intr !== 1'b0 || overrun !== 1'b1) begin
            bad++;
            $display("FAIL ovr_drained: got intr=%b ovr=%b, want 0 1", cpu_intr, overrun);
        end
        ack();
        send(8'h29);
        total++;
        if (cpu_intr !== 1'b1 || ascii_out !== 8'h20) begin
            bad++;
            $display("FAIL empty_ack: got intr=%b ascii=%h, want 1 20", cpu_intr, ascii_out);
        end
        ack();
        total++;
        if (cpu_intr !== 1'b0) begin
            bad++;
            $display("FAIL empty_ack_pop: got intr=%b, want 0", cpu_intr);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp [4];
        exp = '{8'h20, 8'h20, 8'h20, 8'h0D};
        do_reset();
        for (int i = 0; i < 4; i++) send(8'h29);
        @(negedge clk);
        scan_code  = 8'h5A;
        scan_valid = 1'b1;
        cpu_ack    = 1'b1;
        @(negedge clk);
        scan_valid = 1'b0;
        repeat (9) @(negedge clk);
        total++;
        if (overrun !== 1'b0 || cpu_intr !== 1'b1) begin
            bad++;
            $display("FAIL pushpop_flags: got ovr=%b intr=%b, want 0 1", overrun, cpu_intr);
        end
        cpu_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (ascii_out !== exp[i]) begin
                bad++;
                $display("FAIL pushpop_entry%0d: got ascii=%h, want %h", i, ascii_out, exp[i]);
            end
            ack();
        end
        total++;
        if (cpu_intr !== 1'b0) begin
            bad++;
            $display("FAIL pushpop_empty: got intr=%b, want 0", cpu_intr);
        end
    endtask

    task automatic test_ext_reset();
        do_reset();
        send(8'hE0);
        do_reset();
        send(8'h5A);
        total++;
        if (ascii_out !== 8'h0D || cpu_intr !== 1'b1) begin
            bad++;
            $display("FAIL ext_reset_enter: got ascii=%h intr=%b, want 0d 1", ascii_out, cpu_intr);
        end
        ack();
        send(8'hF0);
        do_reset();
        send(8'h1C);
        total++;
        if (ascii_out !== 8'h61) begin
            bad++;
            $display("FAIL brk_reset: got ascii=%h, want 61", ascii_out);
        end
        ack();
        send(8'hE0); send(8'h75);
        total++;
        if (cpu_intr !== 1'b0) begin
            bad++;
            $display("FAIL ext_unmapped: got intr=%b, want 0", cpu_intr);
        end
        send(8'hE0); send(8'hF0); send(8'h5A);
        total++;
        if (cpu_intr !== 1'b0) begin
            bad++;
            $display("FAIL ext_break: got intr=%b, want 0", cpu_intr);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_shift();
        test_caps();
        test_map();
        test_overrun();
        test_back_to_back();
        test_ext_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
